// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding,
// oversampling ratio and helpers for baud division and bit voting.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Oversample tick divisor, rounded to nearest: round(clk_hz / (16 * baud)).
    function automatic int calc_div(input longint clk_hz, input longint baud);
        longint den;
        den = longint'(OVERSAMPLE) * baud;
        return int'((clk_hz + den / 2) / den);
    endfunction

    // Two-of-three vote used to resolve each received bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Occupancy is tracked in a level
// counter, so the pointers simply wrap and full/empty come from the level.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // A push into a full FIFO is only accepted when a pop frees the head slot
    // in the same cycle; a pop on an empty FIFO is ignored.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    // Head byte is forced to zero when nothing is stored so the output is
    // defined from reset onward.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because the read port is gated by empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority voting and a
// FWFT receive FIFO with sticky framing-error and overrun flags.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a synchronized high-to-low edge on rxd
// START  | validating the start bit; a voted 1 is a glitch, back to IDLE
// DATA   | shifting in 8 data bits, LSB first
// STOP   | voting the stop bit at tick 9; push or flag, then back to IDLE
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          framing_error,
    output logic                          overrun,
    input  logic                          err_clear
);

    localparam int DIV   = calc_div(longint'(CLK_HZ), longint'(BAUD));
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [1:0]       sync_q;
    logic             rxd_s;
    logic             rxd_prev_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;

    rx_state_e        state_q;
    logic [3:0]       tick_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [1:0]       samp_q;
    logic             bit_val;
    logic             push_q;
    logic             fe_set_q;

    logic             framing_error_q, framing_error_d;
    logic             overrun_q, overrun_d;
    logic             fifo_full, fifo_empty, pop;

    assign rxd_s = sync_q[1];

    // Two-flop synchronizer plus one delayed copy for start-edge detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_q     <= 2'b11;
            rxd_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rxd};
            rxd_prev_q <= rxd_s;
        end
    end

    // Free-running oversample divider, tick on its last count.
    always_comb begin
        tick      = (div_cnt_q == DIV_W'(DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

    // Divider register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) div_cnt_q <= '0;
        else                div_cnt_q <= div_cnt_d;
    end

    // Samples from ticks 7 and 8 vote together with the live sample at tick 9.
    assign bit_val = maj3(samp_q[0], samp_q[1], rxd_s);

    // Receive FSM. Returning to IDLE at tick 9 of the stop bit leaves room to
    // catch a following start edge. Start detection needs the previous
    // synchronized sample to be high, so a held-low break line produces one
    // framing error and nothing more until the line has gone high again.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            push_q     <= 1'b0;
            fe_set_q   <= 1'b0;
        end else begin
            push_q   <= 1'b0;
            fe_set_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (rxd_prev_q && !rxd_s) begin
                    state_q    <= ST_START;
                    tick_cnt_q <= '0;
                end
            end else if (tick) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
                if (tick_cnt_q == 4'd7) samp_q[0] <= rxd_s;
                if (tick_cnt_q == 4'd8) samp_q[1] <= rxd_s;
                case (state_q)
                    ST_START: begin
                        if (tick_cnt_q == 4'd9 && bit_val) begin
                            state_q <= ST_IDLE;
                        end else if (tick_cnt_q == 4'd15) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (tick_cnt_q == 4'd9) shift_q <= {bit_val, shift_q[7:1]};
                        if (tick_cnt_q == 4'd15) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_q <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (tick_cnt_q == 4'd9) begin
                            state_q <= ST_IDLE;
                            if (bit_val) push_q   <= 1'b1;
                            else         fe_set_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign pop = rx_valid & rx_ready;

    // Sticky flags: a set in the same cycle as err_clear wins.
    always_comb begin
        framing_error_d = fe_set_q | (framing_error_q & ~err_clear);
        overrun_d       = (push_q & fifo_full & ~pop) | (overrun_q & ~err_clear);
    end

    // Flag registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;
    assign rx_valid      = ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_clk),
        .rst_ni      (reset_reset_n),
        .push_i      (push_q),
        .push_data_i (shift_q),
        .pop_i       (pop),
        .rd_data_o   (rx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

endmodule
